// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter with one-entry frame stage; `I2S_TX_REPEAT_ON_UNDERRUN_EN repeats the last frame on underrun
module i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata,
    output logic                  underrun
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = $clog2(BCLK_DIV + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_BITS - 2);

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_cnt_nxt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] load_frame;
    logic [FRAME_BITS-1:0] refill_frame;
    logic [DATA_WIDTH-1:0] stage_left;
    logic [DATA_WIDTH-1:0] stage_right;
    logic                  stage_full;
    logic                  stage_full_nxt;
    logic                  fall_event;
    logic                  frame_load;
    logic                  accept;

    // Both slots laid out MSB-first, each sample left-justified and zero-padded to the slot.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [DATA_WIDTH-1:0] l,
                                                         input logic [DATA_WIDTH-1:0] r);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1 -: DATA_WIDTH] = l;
        f[SLOT_WIDTH-1 -: DATA_WIDTH] = r;
        return f;
    endfunction

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [DATA_WIDTH-1:0] last_left;
    logic [DATA_WIDTH-1:0] last_right;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_left  <= '0;
            last_right <= '0;
        end else if (frame_load && stage_full) begin
            last_left  <= stage_left;
            last_right <= stage_right;
        end
    end

    assign refill_frame = pack_frame(last_left, last_right);
`else
    assign refill_frame = '0;
`endif

    always_comb begin
        fall_event     = (div_cnt == DIV_LAST) && i2s_bclk;
        bit_cnt_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        frame_load     = fall_event && (bit_cnt == BIT_LAST);
        accept         = s_valid && s_ready;
        load_frame     = stage_full ? pack_frame(stage_left, stage_right) : refill_frame;
        // A beat taken on the load cycle of an empty stage is kept for the following frame.
        stage_full_nxt = accept ? 1'b1 : (frame_load ? 1'b0 : stage_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_LAST;
            i2s_bclk    <= 1'b0;
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
            shift_reg   <= '0;
            stage_left  <= '0;
            stage_right <= '0;
            stage_full  <= 1'b0;
            s_ready     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_LAST) begin
                i2s_bclk <= ~i2s_bclk;
            end
            underrun <= frame_load && !stage_full;
            if (fall_event) begin
                bit_cnt   <= bit_cnt_nxt;
                // Word select leads the data by one bit.
                i2s_lrclk <= (bit_cnt_nxt >= LR_FIRST) && (bit_cnt_nxt <= LR_LAST);
                if (frame_load) begin
                    i2s_sdata <= load_frame[FRAME_BITS-1];
                    shift_reg <= {load_frame[FRAME_BITS-2:0], 1'b0};
                end else begin
                    i2s_sdata <= shift_reg[FRAME_BITS-1];
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (accept) begin
                stage_left  <= s_left;
                stage_right <= s_right;
            end
            stage_full <= stage_full_nxt;
            s_ready    <= !stage_full_nxt;
        end
    end

endmodule
